miss_refill_ctrl: RTL and testbench

- Cache miss handler: the consumer side of the LRU table.
- Reads the stored eviction way for the missing set and picks a victim way.
- Writes back a dirty victim line, then fills the new line from memory.
- Finally writes the accessed way back into the LRU table and updates the tag array.
- Sits between the hit/miss detector and the memory interface of the 4-way, 128-set cache controller.

---
 rtl/cache_ctrl_pkg.sv | 27 ++
 rtl/victim_select.sv | 25 ++
 rtl/miss_refill_ctrl.sv | 136 +++++++++++++
 tb/tb_miss_refill_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared widths, FSM state type and beat-address helper for the cache miss/refill path.
package cache_ctrl_pkg;

  localparam int INDEX_W = 7;
  localparam int TAG_W   = 21;
  localparam int WAYS    = 4;
  localparam int WAY_W   = 2;
  localparam int BEAT_W  = 2;
  localparam int ADDR_W  = TAG_W + INDEX_W + BEAT_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WRITEBACK,
    S_FILL,
    S_UPDATE
  } state_t;

  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [TAG_W-1:0]   tag,
    input logic [INDEX_W-1:0] idx,
    input logic [BEAT_W-1:0]  beat
  );
    return {tag, idx, beat, 2'b00};
  endfunction

endpackage

// File: rtl/victim_select.sv
// Combinational victim-way choice for a miss. With MISS_REFILL_INVALID_FIRST_EN defined,
// the lowest-numbered invalid way wins over the LRU eviction way.
module victim_select
  import cache_ctrl_pkg::*;
(
  input  logic [WAY_W-1:0] i_evict_way,
  input  logic [WAYS-1:0]  i_way_valid,
  output logic [WAY_W-1:0] o_victim_way
);

`ifdef MISS_REFILL_INVALID_FIRST_EN
  // Scan from the top down so the lowest invalid way is the last one written.
  always_comb begin
    o_victim_way = i_evict_way;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!i_way_valid[i]) o_victim_way = WAY_W'(i);
    end
  end
`else
  logic w_unused_valid;
  assign w_unused_valid = ^i_way_valid;
  assign o_victim_way   = i_evict_way;
`endif

endmodule

// File: rtl/miss_refill_ctrl.sv
// Cache miss handler: picks a victim, writes back a dirty line, refills from memory, then
// updates LRU and tag arrays. Optional invalid-way-first victim choice: MISS_REFILL_INVALID_FIRST_EN.
module miss_refill_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_valid,
  output logic               miss_ready,
  input  logic [INDEX_W-1:0] miss_index,
  input  logic [TAG_W-1:0]   miss_tag,
  output logic [INDEX_W-1:0] lru_index,
  input  logic [WAY_W-1:0]   evict_way,
  input  logic [WAYS-1:0]    way_valid,
  output logic               lru_update,
  output logic [WAY_W-1:0]   lru_accessed_way,
  output logic [WAY_W-1:0]   victim_way,
  input  logic               victim_dirty,
  input  logic [TAG_W-1:0]   victim_tag,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BEAT_W-1:0]  mem_beat,
  input  logic               mem_ack,
  output logic               tag_we,
  output logic               miss_done,
  output logic               busy
);

  state_t             r_state, w_state_nxt;
  logic [INDEX_W-1:0] r_index;
  logic [TAG_W-1:0]   r_tag;
  logic [TAG_W-1:0]   r_wb_tag;
  logic [WAY_W-1:0]   r_victim_way;
  logic               r_victim_valid;
  logic [BEAT_W-1:0]  r_beat;
  logic [WAY_W-1:0]   w_victim;
  logic               w_last_beat;

  victim_select u_victim_select (
    .i_evict_way (evict_way),
    .i_way_valid (way_valid),
    .o_victim_way(w_victim)
  );

  assign w_last_beat = (r_beat == {BEAT_W{1'b1}});
  assign victim_way  = r_victim_way;
  assign mem_beat    = r_beat;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Combinational outputs are forced low while reset is held, not just after the edge.
  always_comb begin
    w_state_nxt      = r_state;
    miss_ready       = 1'b0;
    lru_index        = r_index;
    lru_update       = 1'b0;
    lru_accessed_way = '0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    tag_we           = 1'b0;
    miss_done        = 1'b0;
    busy             = (r_state != S_IDLE);
    if (!reset) begin
      w_state_nxt = S_IDLE;
      lru_index   = '0;
      busy        = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          miss_ready = 1'b1;
          lru_index  = miss_index;
          if (miss_valid) w_state_nxt = S_SELECT;
        end
        S_SELECT: begin
          w_state_nxt = (r_victim_valid && victim_dirty) ? S_WRITEBACK : S_FILL;
        end
        S_WRITEBACK: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = beat_addr(r_wb_tag, r_index, r_beat);
          if (mem_ack && w_last_beat) w_state_nxt = S_FILL;
        end
        S_FILL: begin
          mem_req  = 1'b1;
          mem_addr = beat_addr(r_tag, r_index, r_beat);
          if (mem_ack && w_last_beat) w_state_nxt = S_UPDATE;
        end
        S_UPDATE: begin
          lru_update       = 1'b1;
          lru_accessed_way = r_victim_way;
          tag_we           = 1'b1;
          miss_done        = 1'b1;
          w_state_nxt      = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The beat counter wraps to 0 on the last writeback ack, so FILL starts at beat 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_index        <= '0;
      r_tag          <= '0;
      r_wb_tag       <= '0;
      r_victim_way   <= '0;
      r_victim_valid <= 1'b0;
      r_beat         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_valid) begin
            r_index        <= miss_index;
            r_tag          <= miss_tag;
            r_victim_way   <= w_victim;
            r_victim_valid <= way_valid[w_victim];
          end
        end
        S_SELECT: begin
          r_beat <= '0;
          if (r_victim_valid && victim_dirty) r_wb_tag <= victim_tag;
        end
        S_WRITEBACK, S_FILL: begin
          if (mem_ack) r_beat <= r_beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miss_refill_ctrl.sv
// Self-checking bench for miss_refill_ctrl: table-driven misses with a memory-beat scoreboard,
// plus reset, backpressure and mid-writeback abort sequences.
module tb_miss_refill_ctrl;
  import cache_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               miss_valid = 1'b0;
  logic               miss_ready;
  logic [INDEX_W-1:0] miss_index = '0;
  logic [TAG_W-1:0]   miss_tag = '0;
  logic [INDEX_W-1:0] lru_index;
  logic [WAY_W-1:0]   evict_way = '0;
  logic [WAYS-1:0]    way_valid = '0;
  logic               lru_update;
  logic [WAY_W-1:0]   lru_accessed_way;
  logic [WAY_W-1:0]   victim_way;
  logic               victim_dirty = 1'b0;
  logic [TAG_W-1:0]   victim_tag = '0;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BEAT_W-1:0]  mem_beat;
  logic               mem_ack = 1'b0;
  logic               tag_we;
  logic               miss_done;
  logic               busy;

  miss_refill_ctrl dut (
    .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_index(miss_index), .miss_tag(miss_tag), .lru_index(lru_index),
    .evict_way(evict_way), .way_valid(way_valid), .lru_update(lru_update),
    .lru_accessed_way(lru_accessed_way), .victim_way(victim_way),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_beat(mem_beat), .mem_ack(mem_ack),
    .tag_we(tag_we), .miss_done(miss_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [WAYS-1:0]    wv;
    logic [WAY_W-1:0]   ev;
    logic               dirty;
    logic [TAG_W-1:0]   vtag;
    int                 waits;
    logic [WAY_W-1:0]   exp_way;
    logic               exp_wb;
  } vec_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] beat;
  } beat_t;

  beat_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                              input logic [WAYS-1:0] wv, input logic [WAY_W-1:0] ev,
                              input logic dirty, input logic [TAG_W-1:0] vtag, input int waits,
                              input logic [WAY_W-1:0] exp_way, input logic exp_wb);
    vec_t v;
    v.idx = idx; v.tag = tag; v.wv = wv; v.ev = ev; v.dirty = dirty; v.vtag = vtag;
    v.waits = waits; v.exp_way = exp_way; v.exp_wb = exp_wb;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one miss from acceptance to completion (or to a reset abort at a writeback beat).
  task automatic run_miss(input vec_t v, input bit hold_valid, input int abort_beat);
    int    cyc;
    int    wcnt;
    int    exp_done;
    bit    done;
    bit    aborted;
    bit    prev_req;
    bit    prev_ack;
    beat_t prev;
    beat_t e;
    miss_index = v.idx; miss_tag = v.tag; way_valid = v.wv; evict_way = v.ev;
    victim_dirty = v.dirty; victim_tag = v.vtag; miss_valid = 1'b1;
    #1;
    check("miss_ready_idle", 64'(miss_ready), 64'(1'b1));
    check("lru_index_idle", 64'(lru_index), 64'(v.idx));
    sb.delete();
    if (v.exp_wb)
      for (int b = 0; b < 4; b++) sb.push_back('{1'b1, {v.vtag, v.idx, BEAT_W'(b), 2'b00}, BEAT_W'(b)});
    for (int b = 0; b < 4; b++) sb.push_back('{1'b0, {v.tag, v.idx, BEAT_W'(b), 2'b00}, BEAT_W'(b)});
    exp_done = 2 + (v.exp_wb ? 8 : 4) * (v.waits + 1);
    tick();
    if (!hold_valid) miss_valid = 1'b0;
    cyc = 1;
    check("victim_way", 64'(victim_way), 64'(v.exp_way));
    check("lru_index_latched", 64'(lru_index), 64'(v.idx));
    check("busy_select", 64'(busy), 64'(1'b1));
    wcnt = 0; done = 0; aborted = 0; prev_req = 0; prev_ack = 0; prev = '{1'b0, '0, '0};
    while (!done && cyc < 400) begin
      if (lru_update) begin
        check("done_cycle", 64'(cyc), 64'(exp_done));
        check("lru_accessed_way", 64'(lru_accessed_way), 64'(v.exp_way));
        check("tag_we", 64'(tag_we), 64'(1'b1));
        check("miss_done", 64'(miss_done), 64'(1'b1));
        check("mem_req_after_last", 64'(mem_req), 64'(1'b0));
        check("beats_left", 64'(sb.size()), 64'(0));
        done = 1;
      end else begin
        if (hold_valid) check("ready_while_busy", 64'(miss_ready), 64'(1'b0));
        if (mem_req) begin
          if (prev_req && !prev_ack) begin
            check("stable_addr", 64'(mem_addr), 64'(prev.addr));
            check("stable_we", 64'(mem_we), 64'(prev.we));
            check("stable_beat", 64'(mem_beat), 64'(prev.beat));
          end
          prev = '{mem_we, mem_addr, mem_beat};
          if (abort_beat >= 0 && mem_we && int'(mem_beat) == abort_beat) begin
            reset = 1'b0;
            aborted = 1;
            done = 1;
          end else if (wcnt == v.waits) begin
            mem_ack = 1'b1;
            wcnt = 0;
            if (sb.size() == 0) begin
              check("extra_beat", 64'(1'b1), 64'(1'b0));
            end else begin
              e = sb.pop_front();
              check("beat_we", 64'(mem_we), 64'(e.we));
              check("beat_addr", 64'(mem_addr), 64'(e.addr));
              check("beat_num", 64'(mem_beat), 64'(e.beat));
            end
          end else begin
            wcnt++;
          end
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
      end
      if (!done) begin
        tick();
        mem_ack = 1'b0;
        cyc++;
      end
    end
    if (!done) check("timeout", 64'(1'b1), 64'(1'b0));
    tick();
    mem_ack = 1'b0;
    if (aborted) begin
      check("abort_mem_req", 64'(mem_req), 64'(1'b0));
      check("abort_busy", 64'(busy), 64'(1'b0));
      check("abort_ready_in_reset", 64'(miss_ready), 64'(1'b0));
      reset = 1'b1;
      miss_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check("abort_no_strobe", 64'({lru_update, tag_we, miss_done}), 64'(3'b000));
        tick();
      end
      check("abort_idle_ready", 64'(miss_ready), 64'(1'b1));
      sb.delete();
    end else begin
      check("ready_after_done", 64'(miss_ready), 64'(1'b1));
      check("busy_after_done", 64'(busy), 64'(1'b0));
    end
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = mk(7'd5,   21'h01234,  4'b1111, 2'd2, 1'b0, 21'h00000,  0, 2'd2, 1'b0);
    tbl[1] = mk(7'd9,   21'h1F00F,  4'b1111, 2'd1, 1'b1, 21'h00ABC,  0, 2'd1, 1'b1);
`ifdef MISS_REFILL_INVALID_FIRST_EN
    tbl[2] = mk(7'h33,  21'h0BEEF,  4'b1011, 2'd0, 1'b1, 21'h12345,  0, 2'd2, 1'b0);
    tbl[4] = mk(7'd64,  21'h00777,  4'b0000, 2'd3, 1'b1, 21'h0CAFE,  0, 2'd0, 1'b0);
    tbl[5] = mk(7'd0,   21'h00000,  4'b0111, 2'd1, 1'b0, 21'h00001,  0, 2'd3, 1'b0);
`else
    tbl[2] = mk(7'h33,  21'h0BEEF,  4'b1011, 2'd0, 1'b1, 21'h12345,  0, 2'd0, 1'b1);
    tbl[4] = mk(7'd64,  21'h00777,  4'b0000, 2'd3, 1'b1, 21'h0CAFE,  0, 2'd3, 1'b0);
    tbl[5] = mk(7'd0,   21'h00000,  4'b0111, 2'd1, 1'b0, 21'h00001,  0, 2'd1, 1'b0);
`endif
    tbl[3] = mk(7'd127, 21'h1FFFFF, 4'b1111, 2'd3, 1'b1, 21'h155555, 0, 2'd3, 1'b1);

    // Power-on reset.
    tick();
    tick();
    check("reset_ready", 64'(miss_ready), 64'(1'b0));
    check("reset_mem_req", 64'(mem_req), 64'(1'b0));
    check("reset_victim_way", 64'(victim_way), 64'(0));
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_miss(tbl[i], 1'b0, -1);

    // Reset held for two cycles while idle with a pending request.
    miss_valid = 1'b1;
    reset = 1'b0;
    #1;
    check("idle_reset_ready_comb", 64'(miss_ready), 64'(1'b0));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("idle_reset_mem_req", 64'(mem_req), 64'(1'b0));
      check("idle_reset_strobes", 64'({lru_update, tag_we, miss_done}), 64'(3'b000));
      check("idle_reset_ready", 64'(miss_ready), 64'(1'b0));
      check("idle_reset_busy", 64'(busy), 64'(1'b0));
    end
    miss_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("release_ready", 64'(miss_ready), 64'(1'b1));
    tick();

    // Backpressure: 3 wait cycles per beat, request held high while busy.
    run_miss(mk(7'd17, 21'h0A5A5, 4'b1111, 2'd1, 1'b1, 21'h0F0F0, 3, 2'd1, 1'b1), 1'b1, -1);
    run_miss(mk(7'd18, 21'h05A5A, 4'b1111, 2'd0, 1'b0, 21'h00000, 0, 2'd0, 1'b0), 1'b0, -1);

    // Reset while writing back beat 2, then a normal miss.
    run_miss(mk(7'd40, 21'h11111, 4'b1111, 2'd3, 1'b1, 21'h02222, 0, 2'd3, 1'b1), 1'b0, 2);
    run_miss(tbl[1], 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
